// File: rtl/decode_stage_pkg.sv
// Shared ISA definitions and decode helper for the decode stage.
// Holds the opcode/funct encodings that the ALU also uses, the NOP word, the
// decoded-control and operand-bundle structs, and a pure decode function.
package decode_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {RS_ZERO, RS_REG, RS_IMM} rs_sel_e;
  typedef enum logic [1:0] {RT_ZERO, RT_REG, RT_SEXT, RT_ZEXT} rt_sel_e;

  typedef struct packed {
    logic       legal;
    logic       use_a;   // instr[25:21] is read
    logic       use_b;   // instr[20:16] is read
    rs_sel_e    rs_sel;
    rt_sel_e    rt_sel;
    logic [5:0] funct;
    logic [4:0] shamt;
    logic [4:0] dest;
  } dec_t;

  typedef struct packed {
    logic [31:0] rs;
    logic [31:0] rt;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [4:0]  dest;
    logic        we;
  } bundle_t;

  function automatic logic funct_ok(input logic [5:0] f);
    case (f)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR,
      FN_SLL, FN_SRL, FN_SRA: funct_ok = 1'b1;
      default:                funct_ok = 1'b0;
    endcase
  endfunction

  // Unsupported words fall through with legal=0, funct=add and zero operands.
  function automatic dec_t decode(input logic [31:0] w);
    dec_t d;
    d        = '0;
    d.rs_sel = RS_ZERO;
    d.rt_sel = RT_ZERO;
    d.funct  = FN_ADD;
    case (w[31:26])
      OP_RTYPE: begin
        if (funct_ok(w[5:0])) begin
          d.legal  = 1'b1;
          d.use_a  = 1'b1;
          d.use_b  = 1'b1;
          d.rs_sel = RS_REG;
          d.rt_sel = RT_REG;
          d.funct  = w[5:0];
          d.shamt  = w[10:6];
          d.dest   = w[15:11];
        end
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: begin
        d.legal  = 1'b1;
        d.use_a  = 1'b1;
        d.rs_sel = RS_REG;
        d.rt_sel = (w[31:26] == OP_ADDI) ? RT_SEXT : RT_ZEXT;
        d.dest   = w[20:16];
        case (w[31:26])
          OP_ANDI: d.funct = FN_AND;
          OP_ORI:  d.funct = FN_OR;
          OP_XORI: d.funct = FN_XOR;
          default: d.funct = FN_ADD;
        endcase
      end
      OP_LUI: begin
        d.legal  = 1'b1;
        d.rs_sel = RS_IMM;
        d.funct  = FN_SLL;
        d.shamt  = 5'd16;
        d.dest   = w[20:16];
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// 32x32 register file, two asynchronous read ports, one write port on clk.
// r0 always reads 0 and ignores writes. With WB_BYPASS=1 a read of the index
// being written this cycle returns the incoming wdata instead of the old value.
// Ports: clk; ra_addr/ra_data, rb_addr/rb_data read ports; we/waddr/wdata write.
module decode_stage_regfile #(
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic [4:0]  ra_addr,
  output logic [31:0] ra_data,
  input  logic [4:0]  rb_addr,
  output logic [31:0] rb_data,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  // No reset: contents survive rst and flush.
  logic [31:0] mem [0:31];

  always_ff @(posedge clk) begin
    if (we && waddr != 5'd0) mem[waddr] <= wdata;
  end

  function automatic logic [31:0] rd(input logic [4:0] a);
    if (a == 5'd0)                          rd = '0;
    else if (WB_BYPASS && we && waddr == a) rd = wdata;
    else                                    rd = mem[a];
  endfunction

  assign ra_data = rd(ra_addr);
  assign rb_data = rd(rb_addr);

endmodule

// File: rtl/decode_stage.sv
// Decode / register-read stage feeding the combinational ALU.
// Decodes a 32-bit MIPS-style word, reads the register file, interlocks on
// busy source registers and presents the operand bundle through a valid/ready
// output register (1-cycle latency).
// Ports: clk, rst (sync, active high); in_valid/in_ready/in_instr from fetch;
// flush; wb_we/wb_addr/wb_data writeback; out_valid/out_ready handshake with
// out_rs/out_rt/out_funct/out_shamt/out_dest/out_we bundle; illegal pulse.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter bit WB_BYPASS  = 1'b1,
  parameter bit SCOREBOARD = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic        flush,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rs,
  output logic [31:0] out_rt,
  output logic [5:0]  out_funct,
  output logic [4:0]  out_shamt,
  output logic [4:0]  out_dest,
  output logic        out_we,
  output logic        illegal
);

  dec_t        dec;
  logic [4:0]  src_a, src_b;
  logic [31:0] ra_data, rb_data;
  logic [31:1] busy;
  logic [31:0] busy_now, busy_n, wb_clr;
  logic        hazard, stall, accept;
  bundle_t     bundle_n, out_q;

  assign dec   = decode(in_instr);
  assign src_a = in_instr[25:21];
  assign src_b = in_instr[20:16];

  decode_stage_regfile #(.WB_BYPASS(WB_BYPASS)) u_rf (
    .clk    (clk),
    .ra_addr(src_a),
    .ra_data(ra_data),
    .rb_addr(src_b),
    .rb_data(rb_data),
    .we     (wb_we),
    .waddr  (wb_addr),
    .wdata  (wb_data)
  );

  // A register whose writeback lands this cycle is already readable through
  // the bypass, so it stops counting as busy right away.
  assign wb_clr   = (WB_BYPASS && wb_we) ? (32'd1 << wb_addr) : '0;
  assign busy_now = {busy, 1'b0} & ~wb_clr;

  always_comb begin
    hazard = 1'b0;
    if (dec.use_a && busy_now[src_a]) hazard = 1'b1;
    if (dec.use_b && busy_now[src_b]) hazard = 1'b1;
  end

  assign stall    = SCOREBOARD && in_valid && hazard;
  assign in_ready = ~stall & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready & ~flush;

  always_comb begin
    bundle_n       = '0;
    bundle_n.funct = dec.funct;
    bundle_n.shamt = dec.shamt;
    bundle_n.dest  = dec.dest;
    bundle_n.we    = dec.legal && (dec.dest != 5'd0);
    case (dec.rs_sel)
      RS_REG:  bundle_n.rs = ra_data;
      RS_IMM:  bundle_n.rs = {16'h0000, in_instr[15:0]};
      default: bundle_n.rs = '0;
    endcase
    case (dec.rt_sel)
      RT_REG:  bundle_n.rt = rb_data;
      RT_SEXT: bundle_n.rt = {{16{in_instr[15]}}, in_instr[15:0]};
      RT_ZEXT: bundle_n.rt = {16'h0000, in_instr[15:0]};
      default: bundle_n.rt = '0;
    endcase
  end

  // Clear first, then set, so a same-edge set of the same index wins.
  always_comb begin
    busy_n = {busy, 1'b0};
    if (wb_we) busy_n[wb_addr] = 1'b0;
    if (accept && bundle_n.we) busy_n[bundle_n.dest] = 1'b1;
    busy_n[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_q     <= '0;
      illegal   <= 1'b0;
      busy      <= '0;
    end else begin
      illegal <= accept & ~dec.legal;
      busy    <= flush ? '0 : busy_n[31:1];
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_q     <= bundle_n;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign out_rs    = out_q.rs;
  assign out_rt    = out_q.rt;
  assign out_funct = out_q.funct;
  assign out_shamt = out_q.shamt;
  assign out_dest  = out_q.dest;
  assign out_we    = out_q.we;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed instruction sequence with literal checks,
// plus an ISA-level reference model compared against the DUT every cycle.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, wb_we, out_valid, out_ready;
  logic        out_we, illegal;
  logic [31:0] in_instr, wb_data, out_rs, out_rt;
  logic [4:0]  wb_addr, out_shamt, out_dest;
  logic [5:0]  out_funct;

  always #5 clk = ~clk;

  decode_stage #(.WB_BYPASS(1'b1), .SCOREBOARD(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_rs(out_rs), .out_rt(out_rt), .out_funct(out_funct),
    .out_shamt(out_shamt), .out_dest(out_dest), .out_we(out_we),
    .illegal(illegal)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (architectural view) ----------------
  logic [31:0] m_reg [32];
  logic [31:0] m_busy;
  logic        m_ov, m_ill, m_we;
  logic [31:0] m_rs, m_rt;
  logic [5:0]  m_fn;
  logic [4:0]  m_sh, m_dst;

  // Register value visible this cycle, including a same-cycle writeback.
  function automatic logic [31:0] rdv(input logic [4:0] i);
    if (i == 0) return 32'h0;
    if (wb_we && wb_addr == i) return wb_data;
    return m_reg[i];
  endfunction

  function automatic bit src_busy(input logic [4:0] i);
    return (i != 0) && m_busy[i] && !(wb_we && wb_addr == i);
  endfunction

  logic        d_ok, d_ua, d_ub, e_rdy, e_acc, e_stall;
  logic [31:0] d_rs, d_rt;
  logic [5:0]  d_fn;
  logic [4:0]  d_sh, d_dst;

  task automatic ref_decode(input logic [31:0] w);
    logic [5:0]  op;
    logic [15:0] imm;
    op = w[31:26]; imm = w[15:0];
    d_ok = 0; d_ua = 0; d_ub = 0; d_rs = 0; d_rt = 0; d_fn = 6'h20; d_sh = 0; d_dst = 0;
    if (op == 6'h00) begin
      if (w[5:0] inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h00, 6'h02, 6'h03}) begin
        d_ok = 1; d_ua = 1; d_ub = 1;
        d_rs = rdv(w[25:21]); d_rt = rdv(w[20:16]);
        d_fn = w[5:0]; d_sh = w[10:6]; d_dst = w[15:11];
      end
    end else if (op inside {6'h08, 6'h0C, 6'h0D, 6'h0E}) begin
      d_ok = 1; d_ua = 1; d_dst = w[20:16];
      d_rs = rdv(w[25:21]);
      d_rt = (op == 6'h08) ? 32'($signed(imm)) : {16'h0, imm};
      d_fn = (op == 6'h08) ? 6'h20 : (op == 6'h0C) ? 6'h24 : (op == 6'h0D) ? 6'h25 : 6'h26;
    end else if (op == 6'h0F) begin
      d_ok = 1; d_rs = {16'h0, imm}; d_fn = 6'h00; d_sh = 5'd16; d_dst = w[20:16];
    end
  endtask

  always @(negedge clk) begin
    ref_decode(in_instr);
    e_stall = in_valid && ((d_ua && src_busy(in_instr[25:21])) || (d_ub && src_busy(in_instr[20:16])));
    e_rdy   = !e_stall && (!m_ov || out_ready);
    if (chk_en) begin
      chk("m.in_ready",  32'(in_ready),  32'(e_rdy));
      chk("m.out_valid", 32'(out_valid), 32'(m_ov));
      chk("m.illegal",   32'(illegal),   32'(m_ill));
      chk("m.out_we",    32'(out_we),    32'(m_we));
      chk("m.out_rs",    out_rs,         m_rs);
      chk("m.out_rt",    out_rt,         m_rt);
      chk("m.out_funct", 32'(out_funct), 32'(m_fn));
      chk("m.out_shamt", 32'(out_shamt), 32'(m_sh));
      chk("m.out_dest",  32'(out_dest),  32'(m_dst));
    end
    // advance model to the state after the coming posedge
    e_acc = in_valid && e_rdy && !flush && !rst;
    if (wb_we && wb_addr != 0) m_reg[wb_addr] = wb_data;
    if (rst) begin
      m_ov = 0; m_ill = 0; m_we = 0; m_rs = 0; m_rt = 0; m_fn = 0; m_sh = 0; m_dst = 0; m_busy = 0;
    end else begin
      if (wb_we) m_busy[wb_addr] = 1'b0;
      m_ill = e_acc && !d_ok;
      if (flush) begin
        m_ov = 0; m_busy = 0;
      end else if (e_acc) begin
        m_ov = 1; m_rs = d_rs; m_rt = d_rt; m_fn = d_fn; m_sh = d_sh; m_dst = d_dst;
        m_we = d_ok && (d_dst != 0);
        if (m_we) m_busy[d_dst] = 1'b1;
      end else if (out_ready) begin
        m_ov = 0;
      end
      m_busy[0] = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit r, input bit v, input logic [31:0] ins, input bit ordy,
                      input bit fl, input bit we, input logic [4:0] wa, input logic [31:0] wd);
    @(posedge clk); #1;
    rst = r; in_valid = v; in_instr = ins; out_ready = ordy; flush = fl;
    wb_we = we; wb_addr = wa; wb_data = wd;
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] ins);
    step(0, 1, ins, 1, 0, 0, 0, 0);
  endtask

  task automatic idle();
    step(0, 0, 32'h0, 1, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
    m_busy = 0; m_ov = 0; m_ill = 0; m_we = 0; m_rs = 0; m_rt = 0; m_fn = 0; m_sh = 0; m_dst = 0;
    rst = 1; in_valid = 0; in_instr = 0; out_ready = 1; flush = 0;
    wb_we = 0; wb_addr = 0; wb_data = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0; chk_en = 1;
    @(negedge clk);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_we",    32'(out_we),    32'd0);
    chk("rst.illegal",   32'(illegal),   32'd0);
    chk("rst.out_rs",    out_rs,         32'd0);

    for (int i = 1; i < 32; i++) step(0, 0, 32'h0, 1, 0, 1, 5'(i), 32'h100 + i);

    // ADDI r1,r0,-1
    send(32'h2001FFFF);
    chk("addi.in_ready", 32'(in_ready), 32'd1);
    idle();
    chk("addi.valid", 32'(out_valid), 32'd1);
    chk("addi.rt",    out_rt,         32'hFFFFFFFF);
    chk("addi.funct", 32'(out_funct), 32'h20);
    chk("addi.dest",  32'(out_dest),  32'd1);
    chk("addi.we",    32'(out_we),    32'd1);

    // ADD r3,r1,r2 stalls on busy r1 until its writeback cycle
    send(32'h00221820);
    chk("raw.stall0", 32'(in_ready), 32'd0);
    send(32'h00221820);
    chk("raw.stall1", 32'(in_ready), 32'd0);
    step(0, 1, 32'h00221820, 1, 0, 1, 5'd1, 32'hDEADBEEF);
    chk("raw.issue", 32'(in_ready), 32'd1);
    idle();
    chk("raw.rs",   out_rs,        32'hDEADBEEF);
    chk("raw.rt",   out_rt,        32'h00000102);
    chk("raw.dest", 32'(out_dest), 32'd3);

    // LUI r4,0x1234 (writeback r3 alongside)
    step(0, 1, 32'h3C041234, 1, 0, 1, 5'd3, 32'h33);
    chk("lui.in_ready", 32'(in_ready), 32'd1);
    step(0, 0, 32'h0, 1, 0, 1, 5'd4, 32'h44);
    chk("lui.rs",    out_rs,         32'h00001234);
    chk("lui.funct", 32'(out_funct), 32'h00);
    chk("lui.shamt", 32'(out_shamt), 32'd16);
    chk("lui.dest",  32'(out_dest),  32'd4);

    // ORI r5,r2,0xF0 then hold the bundle for 3 cycles
    send(32'h344500F0);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 32'h38060F0F, 0, 0, 0, 0, 0);
      chk("hold.in_ready", 32'(in_ready),  32'd0);
      chk("hold.valid",    32'(out_valid), 32'd1);
      chk("hold.rs",       out_rs,         32'h00000102);
      chk("hold.rt",       out_rt,         32'h000000F0);
      chk("hold.funct",    32'(out_funct), 32'h25);
      chk("hold.dest",     32'(out_dest),  32'd5);
    end
    send(32'h38060F0F);                  // XORI r6,r0,0x0F0F
    chk("resume.in_ready", 32'(in_ready), 32'd1);
    send(32'h012A4024);                  // AND r8,r9,r10
    chk("b2b.in_ready", 32'(in_ready),  32'd1);
    chk("xori.rt",      out_rt,         32'h00000F0F);
    chk("xori.funct",   32'(out_funct), 32'h26);
    send(32'h8C070000);                  // unsupported opcode 100011
    chk("and.rs", out_rs, 32'h00000109);
    chk("and.rt", out_rt, 32'h0000010A);
    send(32'h00E04820);                  // ADD r9,r7,r0: r7 must not be busy
    chk("ill.in_ready", 32'(in_ready),  32'd1);
    chk("ill.pulse",    32'(illegal),   32'd1);
    chk("ill.we",       32'(out_we),    32'd0);
    chk("ill.funct",    32'(out_funct), 32'h20);
    chk("ill.rs",       out_rs,         32'd0);

    // flush with busy r5 and a valid bundle; wb r7 in the same cycle
    step(0, 1, 32'h00A05020, 1, 1, 1, 5'd7, 32'h77777777);
    chk("pre.illegal", 32'(illegal),   32'd0);
    chk("pre.valid",   32'(out_valid), 32'd1);
    chk("pre.rs",      out_rs,         32'h00000107);
    idle();
    chk("flush.valid", 32'(out_valid), 32'd0);
    send(32'h00A75820);                  // ADD r11,r5,r7
    chk("flush.busy_clr", 32'(in_ready), 32'd1);
    idle();
    chk("flush.rs", out_rs, 32'h00000105);
    chk("flush.rt", out_rt, 32'h77777777);

    // reset while stalled on r11
    send(32'h01606020);                  // ADD r12,r11,r0
    chk("rstall.in_ready", 32'(in_ready), 32'd0);
    step(1, 1, 32'h01606020, 1, 0, 0, 0, 0);
    send(32'h01606020);
    chk("rstall.valid", 32'(out_valid), 32'd0);
    chk("rstall.ready", 32'(in_ready),  32'd1);
    idle();
    chk("rstall.rs", out_rs, 32'h0000010B);

    // NOP, SUB, SRA, illegal funct
    send(32'h00000000);
    send(32'h00226822);                  // SUB r13,r1,r2
    chk("nop.we",   32'(out_we),   32'd0);
    chk("nop.dest", 32'(out_dest), 32'd0);
    send(32'h00017103);                  // SRA r14,r1,4
    chk("sub.rs", out_rs, 32'hDEADBEEF);
    send(32'h0000001A);
    chk("sra.rt",    out_rt,         32'hDEADBEEF);
    chk("sra.shamt", 32'(out_shamt), 32'd4);
    idle();
    chk("illf.pulse", 32'(illegal), 32'd1);
    repeat (3) idle();

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
